// File: rtl/accumulator_drain.sv
// accumulator_drain: walks every accumulator-buffer entry at the selected element
// width, streams each element out over valid/ready, then clears the buffer with
// a single parallel load of zeros.
//
// Ports:
//   clk, reset_n         clock and asynchronous active-low reset
//   start, bitwidth      drain request and element width select (0:SEW 1:2*SEW 2:4*SEW 3:illegal)
//   busy, done, error    status; done/error are one-cycle pulses at the end of a drain
//   buffer_bank_entry    read address into the buffer
//   buffer_data_read     combinational read data for buffer_bank_entry
//   transfer, clear_data parallel-load strobe and its (all-zero) load value
//   out_data, out_valid, out_ready, out_last   element stream
//
// Build option: define ACC_DRAIN_RELU_EN to replace negative elements with zero.
`timescale 1ns/1ps
module accumulator_drain #(
  parameter int BUFFER_WIDTH = 8,
  parameter int SMALLEST_ELEMENT_WIDTH = 4
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        start,
  input  logic [1:0]                                  bitwidth,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        error,
  output logic [$clog2(BUFFER_WIDTH)-1:0]             buffer_bank_entry,
  input  logic [SMALLEST_ELEMENT_WIDTH*4-1:0]         buffer_data_read,
  output logic                                        transfer,
  output logic [BUFFER_WIDTH*SMALLEST_ELEMENT_WIDTH-1:0] clear_data,
  output logic [SMALLEST_ELEMENT_WIDTH*4-1:0]         out_data,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic                                        out_last
);
  localparam int SEW = SMALLEST_ELEMENT_WIDTH;
  localparam int DW = SEW * 4;
  localparam int AW = $clog2(BUFFER_WIDTH);
  typedef enum logic [2:0] {IDLE, FETCH, SEND, CLEAR, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] bw;
  logic err;
  logic [AW-1:0] rd_ptr, beat, last_idx;
  logic [DW-1:0] elem;
  assign last_idx = AW'((BUFFER_WIDTH >> bw) - 1);
  // Element extraction: keep the low W bits; with ReLU the top bit of the mask
  // picks out the element's sign bit.
  function automatic logic [DW-1:0] f(input logic [DW-1:0] x, input logic [1:0] b);
    logic [DW-1:0] m;
    m = (b == 2'd2) ? {DW{1'b1}} :
        (b == 2'd1) ? {{(DW-2*SEW){1'b0}}, {(2*SEW){1'b1}}} :
                      {{(DW-SEW){1'b0}}, {SEW{1'b1}}};
`ifdef ACC_DRAIN_RELU_EN
    return |(x & m & ~(m >> 1)) ? '0 : (x & m);
`else
    return x & m;
`endif
  endfunction
  assign elem = f(buffer_data_read, bw);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !start ? IDLE : (bitwidth == 2'd3) ? DONE : FETCH;
      FETCH:   state_nx = SEND;
      SEND:    state_nx = (out_ready && beat == last_idx) ? CLEAR : SEND;
      CLEAR:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    error = state == DONE && err;
    transfer = state == CLEAR;
    out_valid = state == SEND;
    out_last = state == SEND && beat == last_idx;
    buffer_bank_entry = rd_ptr;
    clear_data = '0;
  end
  // rd_ptr leads the presented beat by one, so the next element is already on
  // buffer_data_read when the handshake lands; the fetch on the final
  // handshake is simply not taken.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bw <= '0;
      err <= 1'b0;
      rd_ptr <= '0;
      beat <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            bw <= bitwidth;
            err <= bitwidth == 2'd3;
            rd_ptr <= '0;
            beat <= '0;
          end
        FETCH: begin
          out_data <= elem;
          rd_ptr <= rd_ptr + 1'b1;
        end
        SEND:
          if (out_ready && beat != last_idx) begin
            out_data <= elem;
            rd_ptr <= rd_ptr + 1'b1;
            beat <= beat + 1'b1;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_accumulator_drain.sv
// tb_accumulator_drain: directed self-checking bench for accumulator_drain.
`timescale 1ns/1ps
module tb_accumulator_drain;
`ifdef ACC_DRAIN_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif
  logic clk, reset_n, start, busy, done, error, transfer, out_valid, out_ready, out_last;
  logic [1:0] bitwidth, cur_bw;
  logic [2:0] buffer_bank_entry;
  logic [15:0] buffer_data_read, out_data;
  logic [31:0] clear_data, buffer;
  logic [15:0] exp_beats [8];
  int checks, failures;
  accumulator_drain dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bitwidth(bitwidth),
    .busy(busy), .done(done), .error(error),
    .buffer_bank_entry(buffer_bank_entry), .buffer_data_read(buffer_data_read),
    .transfer(transfer), .clear_data(clear_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always_comb begin
    int w;
    w = 4 << cur_bw;
    buffer_data_read = 16'((buffer >> (32'(buffer_bank_entry) * w)) & ((32'd1 << w) - 32'd1));
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic drain(input logic [1:0] b, input logic [31:0] bv, input bit tog, input int n, input int busy_start);
    int k, cyc, first_v, xfer_c, xfer_n, done_c, done_n;
    logic [15:0] prev_d;
    logic [2:0] prev_e;
    bit stall;
    k = 0; cyc = 0; first_v = -1; xfer_c = -1; xfer_n = 0; done_c = -1; done_n = 0; stall = 0;
    prev_d = '0; prev_e = '0;
    buffer = bv; cur_bw = b; bitwidth = b; start = 1'b1; out_ready = 1'b1;
    while (done_n == 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start = cyc == busy_start;
      bitwidth = start ? 2'd3 : b;
      out_ready = tog ? (cyc % 2 == 1) : 1'b1;
      if (out_valid && stall) begin
        chk("stable_data", 32'(out_data), 32'(prev_d));
        chk("stable_entry", 32'(buffer_bank_entry), 32'(prev_e));
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (transfer) begin
        chk("xfer_no_valid", 32'(out_valid), 32'd0);
        chk("clear_data", clear_data, 32'd0);
        xfer_n++;
        xfer_c = cyc;
        buffer = clear_data;
      end
      if (out_valid && out_ready) begin
        if (k < 8) chk("beat", 32'(out_data), 32'(exp_beats[k]));
        chk("last", 32'(out_last), 32'(k == n - 1));
        k++;
      end
      stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_e = buffer_bank_entry;
      if (done) begin
        done_n++;
        done_c = cyc;
        chk("error_clear", 32'(error), 32'd0);
      end
    end
    chk("done_seen", 32'(done_n), 32'd1);
    start = 1'b0;
    @(negedge clk);
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_after", 32'(done), 32'd0);
    chk("beats", 32'(k), 32'(n));
    chk("xfer_cnt", 32'(xfer_n), 32'd1);
    chk("buffer_cleared", buffer, 32'd0);
    if (!tog) begin
      chk("first_valid_cyc", 32'(first_v), 32'd2);
      chk("xfer_cyc", 32'(xfer_c), 32'(n + 2));
      chk("done_cyc", 32'(done_c), 32'(n + 3));
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0; start = 1'b0; bitwidth = 2'd0; cur_bw = 2'd0; out_ready = 1'b0; buffer = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_entry", 32'(buffer_bank_entry), 32'd0);
    chk("rst_flags", {28'd0, done, error, transfer, out_last}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    exp_beats = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, RELU ? 16'h0 : 16'h8};
    drain(2'd0, 32'h87654321, 1'b0, 8, -1);
    exp_beats = '{16'h34, 16'h12, 16'h0A, RELU ? 16'h0 : 16'hF0, 16'h0, 16'h0, 16'h0, 16'h0};
    drain(2'd1, 32'hF00A1234, 1'b0, 4, -1);
    exp_beats = '{RELU ? 16'h0 : 16'hFFFF, RELU ? 16'h0 : 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    drain(2'd2, 32'h8000FFFF, 1'b1, 2, -1);
    buffer = 32'h12345678; cur_bw = 2'd3; bitwidth = 2'd3; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ill_done", 32'(done), 32'd1);
    chk("ill_error", 32'(error), 32'd1);
    chk("ill_valid_xfer", {30'd0, out_valid, transfer}, 32'd0);
    @(negedge clk);
    chk("ill_idle", {29'd0, busy, done, error}, 32'd0);
    chk("ill_buffer", buffer, 32'h12345678);
    buffer = 32'h87654321; cur_bw = 2'd0; bitwidth = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_valid", 32'(out_valid), 32'd1);
    chk("mid_beat2", 32'(out_data), 32'h2);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_entry", 32'(buffer_bank_entry), 32'd0);
    chk("mid_rst_flags", {27'd0, done, error, transfer, out_valid, out_last}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_xfer", 32'(transfer), 32'd0);
    end
    chk("mid_rst_buffer", buffer, 32'h87654321);
    reset_n = 1'b1;
    @(negedge clk);
    exp_beats = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, RELU ? 16'h0 : 16'h8};
    drain(2'd0, 32'h87654321, 1'b0, 8, -1);
    exp_beats = RELU ? '{16'h0, 16'h0, 16'h0, 16'h0, 16'h7, 16'h5, 16'h3, 16'h1}
                     : '{16'hF, 16'hD, 16'hB, 16'h9, 16'h7, 16'h5, 16'h3, 16'h1};
    drain(2'd0, 32'h13579BDF, 1'b0, 8, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/accumulator_drain.md
# accumulator_drain

Read-side controller for the accumulator buffer. After a tile completes, it walks every bank entry of the buffer at the active element width and streams each element out on a valid/ready interface. It then clears the buffer with a one-cycle `transfer` of zeros. It sits between the accumulator buffer and the output/activation writeback path, and owns the buffer's read port (`buffer_bank_entry`/`buffer_data_read`) and its `transfer`/`data_in` port.

## Interface
- `BUFFER_WIDTH`, 8: number of smallest-width elements held by the buffer.
- `SMALLEST_ELEMENT_WIDTH`, 4: bits per smallest element (SEW). Buffer is BUFFER_WIDTH*SEW bits.
- `clk` in 1: clock.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `start` in 1: single-cycle request to drain. Sampled only in IDLE.
- `bitwidth` in 2: element width select, sampled with `start`. 0 = SEW, 1 = 2·SEW, 2 = 4·SEW, 3 = illegal.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at the end of a drain.
- `error` out 1: one-cycle pulse, concurrent with `done`, when `bitwidth`=3.
- `buffer_bank_entry` out clog2(BUFFER_WIDTH): read address into the buffer.
- `buffer_data_read` in SEW*4: combinational read data for `buffer_bank_entry`, zero-extended above the element width.
- `transfer` out 1: buffer parallel-load strobe.
- `clear_data` out BUFFER_WIDTH*SEW: value loaded on `transfer`. Constant 0.
- `out_data` out SEW*4: element, zero-extended.
- `out_valid` out 1, `out_ready` in 1: stream handshake.
- `out_last` out 1: marks the final beat.

## Operation
- Entry count N = BUFFER_WIDTH >> bw, where bw is the latched bitwidth. Element width W = SEW << bw.
- FSM states: IDLE, FETCH, SEND, CLEAR, DONE.
- IDLE:
  - `start`=1 with bitwidth 0..2: latch bw, set rd_ptr=0 and beat=0, go to FETCH.
  - `start`=1 with bitwidth 3: go to DONE with the error flag set. No beats, no `transfer`.
- FETCH (one cycle):
  - `buffer_bank_entry`=rd_ptr.
  - out_data <= f(buffer_data_read); rd_ptr++; go to SEND.
- SEND:
  - `out_valid`=1. `buffer_bank_entry`=rd_ptr, which leads the beat being presented by one.
  - On `out_valid && out_ready` with beat≠N-1: out_data <= f(buffer_data_read), rd_ptr++, beat++. Throughput is 1 beat/cycle.
  - On `out_valid && out_ready` with beat=N-1: go to CLEAR.
  - Without a handshake: `out_data`, `out_last` and `buffer_bank_entry` hold stable.
- `out_last` = SEND && beat==N-1.
- rd_ptr wraps modulo BUFFER_WIDTH. The fetch performed on the last handshake is discarded.
- CLEAR: `transfer`=1 for exactly one cycle, loading `clear_data`=0. Go to DONE.
- DONE: `done`=1, plus `error`=1 if flagged. Go to IDLE.
- `start` while busy is ignored.
- The parent must hold `buffer_write_enable` low while `busy`=1.
- f(x) = x[W-1:0] zero-extended to SEW*4 bits. See Configuration for the ReLU variant.

## Timing
- Reset values: state=IDLE; `busy`, `done`, `error`, `transfer`, `out_valid`, `out_last` = 0; `out_data`=0; `buffer_bank_entry`=0.
- `start` at cycle 0 gives first `out_valid` at cycle 2, assuming a registered state change at the cycle 0 edge.
- With `out_ready` held high: beats on cycles 2..N+1, `transfer` on N+2, `done` on N+3, `busy` low on N+4.
- Illegal bitwidth: `done`/`error` at cycle 1.
- Reset asserted mid-drain: immediate return to reset values. No `transfer` is issued, and buffer contents are left intact.
- `transfer` never overlaps `out_valid`.

## Configuration
- `ACC_DRAIN_RELU_EN` defined: f(x) outputs 0 when x[W-1]=1 (negative two's-complement element at width W), otherwise x[W-1:0].
- Undefined: f(x) passes raw bits unchanged.
- No other behaviour differs.

## Test plan
- **bw=0, ready high.** Buffer=0x87654321 (BUFFER_WIDTH=8, SEW=4), `start` -> 8 beats 0x1..0x8, `out_last` on 0x8, `transfer` pulse with `clear_data`=0, then `done`. With RELU_EN, the final beat is 0x0.
- **bw=1, ready high.** Buffer=0xF00A1234 -> beats 0x34, 0x12, 0x0A, 0xF0 (0x00 with RELU_EN); `out_last` on the 4th beat.
- **bw=2, backpressure.** Buffer=0x8000FFFF, `out_ready` toggling 0/1 each cycle -> beats 0xFFFF then 0x8000, each held stable while stalled; RELU_EN gives 0x0000 for both.
- **bw=3.** `start` -> `done`+`error` at cycle 1; no `out_valid`, no `transfer`.
- **Reset mid-drain.** `reset_n` low during the 2nd beat -> all outputs 0 immediately, `transfer` never asserted; a fresh `start` after release drains from entry 0.
- **`start` while busy.** `start` pulsed during SEND -> ignored, beat count stays N, exactly one `done`.
